// File: rtl/edge_detect_multi_pkg.sv
// Shared types and sizing helpers for the multi-channel edge detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a (no flow control in this block).
package edge_pkg;

  // Per-channel event selection: which stable transitions raise evt.
  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } edge_mode_t;

  // The debounce counter must hold values 0..DB_CYCLES.
  function automatic int db_cnt_w(input int db_cycles);
    return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
  endfunction

  localparam int DB_CYCLES_DEF = 4;
  localparam int DB_CNT_W_DEF  = $clog2(DB_CYCLES_DEF + 1);

endpackage

// File: rtl/edge_detect_multi_if.sv
// Bundle of the input, control and event signals of the edge detector.
// Latency: n/a (wiring only).
// Backpressure: none; events are fire-and-forget pulses.
interface edge_detect_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic [NCH-1:0]       sig;
  logic [2*NCH-1:0]     mode;
  logic                 clr_cnt;
  logic [NCH-1:0]       sig_sync;
  logic [NCH-1:0]       sig_rise;
  logic [NCH-1:0]       sig_fall;
  logic [NCH-1:0]       evt;
  logic                 evt_any;
  logic [NCH*CNT_W-1:0] evt_cnt;

  modport master (
    output sig, mode, clr_cnt,
    input  sig_sync, sig_rise, sig_fall, evt, evt_any, evt_cnt
  );

  modport slave (
    input  sig, mode, clr_cnt,
    output sig_sync, sig_rise, sig_fall, evt, evt_any, evt_cnt
  );
endinterface

// File: rtl/edge_detect_multi_chan.sv
// One channel: synchroniser chain, debounce filter, edge pulses, saturating event counter.
// Latency: stable level follows sig SYNC_STAGES+DB_CYCLES edges after first sampling edge.
// Backpressure: none; pulses are single-cycle and the counter saturates instead of wrapping.
module edge_chan
  import edge_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         DB_CYCLES   = 4,
  parameter int         CNT_W       = 8,
  parameter logic       RST_LVL     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig,
  input  edge_mode_t       mode,
  input  logic             clr_cnt,
  output logic             sig_sync,
  output logic             sig_rise,
  output logic             sig_fall,
  output logic             evt,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int               DBW     = db_cnt_w(DB_CYCLES);
  localparam logic [DBW-1:0]   DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [DBW-1:0]         db_cnt;
  logic                   stable;
  logic                   stable_d;
  logic [1:0]             mode_bits;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign mode_bits = mode;

  // Plain shift chain into the clock domain; nothing between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
    end
  end

  // Accept a new level only after DB_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      stable <= RST_LVL;
    end else if (sync_out == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable <= sync_out;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // One-cycle delayed copy of the stable level for edge extraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= RST_LVL;
    end else begin
      stable_d <= stable;
    end
  end

  assign sig_sync = stable;
  assign sig_rise = stable & ~stable_d;
  assign sig_fall = ~stable & stable_d;
  assign evt      = (mode_bits[1] & sig_fall) | (mode_bits[0] & sig_rise);

  // Saturating event count; a clear in the same cycle as an event wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
    end else if (clr_cnt) begin
      evt_cnt <= '0;
    end else if (evt && (evt_cnt != CNT_MAX)) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel debounced edge detector with per-channel event selection and counters.
// Latency: SYNC_STAGES+DB_CYCLES edges from first sampling edge to rise/fall/evt pulse.
// Backpressure: none; all channels independent, simultaneous events reported together.
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int   NCH         = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 4,
  parameter int   CNT_W       = 8,
  parameter logic RST_LVL     = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  edge_detect_multi_if.slave  bus
);

  logic [NCH-1:0]       sync_v;
  logic [NCH-1:0]       rise_v;
  logic [NCH-1:0]       fall_v;
  logic [NCH-1:0]       evt_v;
  logic [NCH*CNT_W-1:0] cnt_v;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .CNT_W       (CNT_W),
      .RST_LVL     (RST_LVL)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig      (bus.sig[i]),
      .mode     (edge_mode_t'(bus.mode[2*i +: 2])),
      .clr_cnt  (bus.clr_cnt),
      .sig_sync (sync_v[i]),
      .sig_rise (rise_v[i]),
      .sig_fall (fall_v[i]),
      .evt      (evt_v[i]),
      .evt_cnt  (cnt_v[i*CNT_W +: CNT_W])
    );
  end

  assign bus.sig_sync = sync_v;
  assign bus.sig_rise = rise_v;
  assign bus.sig_fall = fall_v;
  assign bus.evt      = evt_v;
  assign bus.evt_any  = |evt_v;
  assign bus.evt_cnt  = cnt_v;

endmodule
